// File: rtl/tff_pkg.sv
// Shared types and limits for the T flip-flop counter family.
// Imported by the counter top and its bit cell.
package tff_pkg;

  typedef enum logic {
    CNT_WRAP,
    CNT_SAT
  } cnt_mode_e;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/t_ff_cell.sv
// Single toggle flip-flop bit with synchronous active-low reset
// and a synchronous parallel-load override.
module t_ff_cell
  import tff_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic ld_val,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= INIT;
    end else if (ld) begin
      q <= ld_val;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// Up/down counter built from a row of T flip-flop cells, with
// wrap/saturate mode, terminal-count flag and event pulse.
module tff_counter
  import tff_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt
);

  localparam cnt_mode_e MODE =
    (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH-1:0] RST_V =
    RESET_VAL[WIDTH-1:0];

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("tff_counter: WIDTH out of range");
  end

  logic [WIDTH-1:0] up_all;
  logic [WIDTH-1:0] dn_all;
  logic [WIDTH-1:0] t;
  logic             at_bnd;
  logic             hold;

  // up_all[i]: all bits below i are ones; dn_all[i]: all are zeros
  always_comb begin
    up_all    = '0;
    dn_all    = '0;
    up_all[0] = 1'b1;
    dn_all[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_all[i] = up_all[i-1] & q[i-1];
      dn_all[i] = dn_all[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    at_bnd = up ? (up_all[WIDTH-1] & q[WIDTH-1])
                : (dn_all[WIDTH-1] & ~q[WIDTH-1]);
    hold   = (MODE == CNT_SAT) && at_bnd;
    t      = '0;
    if (en && !hold) begin
      t = up ? up_all : dn_all;
    end
  end

  assign tc = at_bnd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_cell #(
      .INIT(RST_V[i])
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .t     (t[i]),
      .ld    (load),
      .ld_val(d[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      evt <= 1'b0;
    end else if (load) begin
      evt <= 1'b0;
    end else begin
      evt <= en && at_bnd;
    end
  end

endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised synchronous up/down counter built from a row of T flip-flop cells: the next generation of the single-bit toggle flip-flop.
- Adds width, direction, parallel load, selectable wrap/saturate mode, a terminal-count flag and a registered overflow/underflow event pulse.
- Used as the general-purpose counter primitive in the sequential-circuits library: dividers, timers, event counters.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries.
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits, must be < 2**WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (rst=0 resets on posedge clk).
- en  input  1  count enable.
- up  input  1  direction, 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- d  input  WIDTH  load value.
- q  output  WIDTH  counter value (registered).
- tc  output  1  terminal count (combinational from q and up).
- evt  output  1  registered one-cycle overflow/underflow event.

Behaviour:
- One clock, clk. Reset is synchronous and active-low.
- Reset (rst=0 at posedge): q <= RESET_VAL, evt <= 0. Reset has highest priority over load and en.
- Priority order: rst, then load, then en. With all three inactive, q holds and evt <= 0.
- Load (rst=1, load=1): q <= d, evt <= 0, regardless of en/up. There is no event on load.
- Count (rst=1, load=0, en=1): implemented as per-bit toggles.
  - Up: T[0]=1; T[i] = AND of q[i-1:0].
  - Down: T[0]=1; T[i] = AND of ~q[i-1:0].
  - q[i] <= q[i] ^ T[i]. Net effect: q +/- 1 modulo 2**WIDTH.
- Boundary condition: "at boundary" = (up && q == all-ones) || (!up && q == 0).
- tc = at boundary. It is purely combinational, independent of en.
- Wrap mode (SATURATE=0), count at boundary:
  - q wraps (all-ones -> 0, or 0 -> all-ones).
  - evt <= 1 for exactly one cycle.
- Saturate mode (SATURATE=1), count at boundary:
  - All T[i] forced to 0, so q holds.
  - evt <= 1 on every enabled cycle spent at the boundary (sticky attempts are visible).
- Any other cycle: evt <= 0.
- Direction change takes effect in the same cycle as up changes. There is no pipeline.
- Latency: q updates one cycle after the inputs are sampled. evt is aligned with the q update that caused it.
- Reset asserted mid-count: q <= RESET_VAL on that edge and any pending event is discarded (evt <= 0).
- No X propagation on q after reset. Inputs are assumed synchronous to clk.

Decomposition:
- Package tff_pkg:
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
  - localparam MAX_WIDTH = 32.
- Sub-module t_ff_cell: one bit, ports clk, rst (sync active-low), t, q.
  - On reset it loads a per-instance init bit (parameter INIT).
  - It also takes ld/ld_val inputs for the parallel load.
- tff_counter instantiates WIDTH cells via generate, plus the toggle-chain logic, the boundary compare and the evt register.

Test Plan (WIDTH=4, RESET_VAL=0 unless stated):
- Reset with en=1, load=1, d=9: hold rst=0 for 2 edges -> q=0, evt=0. Release with en=1, up=1 -> q counts 1,2,3 on successive edges.
- Wrap up, SATURATE=0:
  - Load d=14, then en=1, up=1 -> q=15 (tc=1), then q=0 with evt=1 for exactly one cycle, then q=1 with evt=0.
  - Down from 0 -> q=15 with evt=1.
- Saturate, SATURATE=1:
  - Load 13, up for 5 cycles -> q=14,15,15,15,15; tc=1 from q=15; evt=1 on each cycle held at 15.
  - Switch up=0 -> q=14, evt=0.
- Priority: load=1, d=5 and en=1, up=1 in the same cycle with q=15 -> q=5, evt=0.
  - rst=0 together with load=1 -> q=RESET_VAL.
- Mid-operation reset, RESET_VAL=3: counting down at q=8, drive rst=0 for one edge -> q=3, evt=0. Counting resumes 2,1,0 with up=0.
- Enable gating: en=0 for 4 cycles at q=7 -> q stays 7, evt=0. Toggle up on alternate cycles with en=1 -> q=8,7,8,7.
